// File: rtl/fpu_cvt.sv
// Multi-cycle int<->float converter: IDLE -> S1 (unpack/normalise) -> S2 (round/pack) -> RESP.
// Fixed three-cycle latency with start/busy/done handshake and saturation/invalid flags.
module fpu_cvt #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned BIAS   = 127,
    parameter int unsigned ROUND  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        instr,
    input  logic [DATA_W-1:0] op,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              inv,
    output logic              busy,
    output logic              done
);
    localparam int unsigned MANT_W = DATA_W - 1 - EXP_W;
    localparam int unsigned LW     = $clog2(DATA_W);
    localparam logic [4:0] OPITOF = 5'h13;
    localparam logic [4:0] OPFTOI = 5'h12;
    localparam logic [DATA_W-1:0] INT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]  EXP_ONES = '1;

    typedef enum logic [1:0] {IDLE, S1, S2, RESP} state_t;
    state_t state, state_n;

    logic              accept;
    logic [4:0]        instr_r;
    logic [DATA_W-1:0] op_r;

    // stage-1 results
    logic              s1_sign, s1_zero, s1_sat;
    logic [EXP_W-1:0]  s1_exp;
    logic [DATA_W-2:0] s1_frac;
    logic [DATA_W-1:0] s1_mag;
    logic              nx_sign, nx_zero, nx_sat;
    logic [EXP_W-1:0]  nx_exp;
    logic [DATA_W-2:0] nx_frac;
    logic [DATA_W-1:0] nx_mag;

    // stage-2 results
    logic [DATA_W-1:0] s2_res, nx2_res;
    logic              s2_ovf, nx2_ovf, s2_inv, nx2_inv;

    // ITOF / FTOI unpack helpers
    logic [DATA_W-1:0] mag_i;
    logic [LW-1:0]     msb_i;
    logic [DATA_W-2:0] norm_i;
    logic [EXP_W-1:0]  exp_i;
    logic              sign_f, zero_f, sat_f;
    logic [EXP_W-1:0]  exp_f;
    logic [31:0]       e_f;
    logic [DATA_W-1:0] sig_f, mag_f;

    // round/pack helpers
    logic [MANT_W-1:0] mant_t;
    logic [MANT_W:0]   mant_sum;
    logic [EXP_W-1:0]  exp_rnd;
    logic              guard, sticky, rnd;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = S1;
            S1:      state_n = S2;
            S2:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ITOF: magnitude, leading-one position, left-justified fraction below the leading one
    always_comb begin
        mag_i = op_r[DATA_W-1] ? -op_r : op_r;
        msb_i = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (mag_i[i]) msb_i = LW'(i);
        end
        norm_i = (DATA_W-1)'(mag_i << (LW'(DATA_W-1) - msb_i));
        exp_i  = EXP_W'(BIAS + 32'(msb_i));
    end

    // FTOI: unbiased exponent drives a left or truncating right shift of {1,mant}
    always_comb begin
        sign_f = op_r[DATA_W-1];
        exp_f  = op_r[DATA_W-2 -: EXP_W];
        e_f    = 32'(exp_f) - 32'(BIAS);
        sig_f  = DATA_W'({1'b1, op_r[MANT_W-1:0]});
        if (e_f >= 32'(MANT_W)) mag_f = sig_f << (e_f - 32'(MANT_W));
        else                    mag_f = sig_f >> (32'(MANT_W) - e_f);
        zero_f = (exp_f == '0) || (32'(exp_f) < 32'(BIAS));
        // only -2^(DATA_W-1) may legally reach the top bit
        sat_f  = (exp_f == EXP_ONES) ||
                 (!zero_f && ((e_f > 32'(DATA_W-1)) ||
                              (mag_f[DATA_W-1] && !(sign_f && (mag_f == INT_MIN)))));
    end

    always_comb begin
        nx_sign = 1'b0;
        nx_zero = 1'b0;
        nx_sat  = 1'b0;
        nx_exp  = '0;
        nx_frac = '0;
        nx_mag  = '0;
        case (instr_r)
            OPITOF: begin
                nx_sign = op_r[DATA_W-1];
                nx_zero = (op_r == '0);
                nx_exp  = exp_i;
                nx_frac = norm_i;
            end
            OPFTOI: begin
                nx_sign = sign_f;
                nx_zero = zero_f;
                nx_sat  = sat_f;
                nx_mag  = mag_f;
            end
            default: ;
        endcase
    end

    // round-to-nearest-even; mantissa carry-out bumps the exponent
    always_comb begin
        mant_t   = s1_frac[DATA_W-2 -: MANT_W];
        guard    = s1_frac[EXP_W-1];
        sticky   = |s1_frac[EXP_W-2:0];
        rnd      = (ROUND != 0) && guard && (sticky || mant_t[0]);
        mant_sum = {1'b0, mant_t} + (MANT_W+1)'(rnd);
        exp_rnd  = s1_exp + EXP_W'(mant_sum[MANT_W]);
        nx2_res  = '0;
        nx2_ovf  = 1'b0;
        nx2_inv  = 1'b0;
        case (instr_r)
            OPITOF: begin
                if (!s1_zero) nx2_res = {s1_sign, exp_rnd, mant_sum[MANT_W-1:0]};
            end
            OPFTOI: begin
                if (s1_sat) begin
                    nx2_res = s1_sign ? INT_MIN : INT_MAX;
                    nx2_ovf = 1'b1;
                end else if (!s1_zero) begin
                    nx2_res = s1_sign ? -s1_mag : s1_mag;
                end
            end
            default: nx2_inv = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            instr_r <= instr;
            op_r    <= op;
        end
        if (state == S1) begin
            s1_sign <= nx_sign;
            s1_zero <= nx_zero;
            s1_sat  <= nx_sat;
            s1_exp  <= nx_exp;
            s1_frac <= nx_frac;
            s1_mag  <= nx_mag;
        end
        if (state == S2) begin
            s2_res <= nx2_res;
            s2_ovf <= nx2_ovf;
            s2_inv <= nx2_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            ovf    <= 1'b0;
            inv    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state == RESP);
            if (state == RESP) begin
                result <= s2_res;
                ovf    <= s2_ovf;
                inv    <= s2_inv;
            end
        end
    end
endmodule

// File: tb/tb_fpu_cvt.sv
// Directed bench for fpu_cvt: vector table on RNE and truncating instances plus handshake/reset sequences.
module tb_fpu_cvt;
    localparam logic [4:0] ITOF = 5'h13;
    localparam logic [4:0] FTOI = 5'h12;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [4:0]  instr;
    logic [15:0] op;
    logic [15:0] result_r, result_t;
    logic        ovf_r, inv_r, busy_r, done_r;
    logic        ovf_t, inv_t, busy_t, done_t;

    int n_cmp = 0;
    int n_err = 0;

    fpu_cvt #(.DATA_W(16), .EXP_W(8), .BIAS(127), .ROUND(1)) u_rne (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .op(op),
        .result(result_r), .ovf(ovf_r), .inv(inv_r), .busy(busy_r), .done(done_r));

    fpu_cvt #(.DATA_W(16), .EXP_W(8), .BIAS(127), .ROUND(0)) u_trc (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .op(op),
        .result(result_t), .ovf(ovf_t), .inv(inv_t), .busy(busy_t), .done(done_t));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [4:0]  ins;
        logic [15:0] opv;
        logic [15:0] res;
        logic [15:0] res_t;
        logic        ov;
        logic        iv;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // one op; lat = cycles from accept edge to done (0 on timeout)
    task automatic issue(input logic [4:0] i, input logic [15:0] o,
                         output int lat, output logic bsy_ok, output logic dn_t);
        @(negedge clk);
        start = 1'b1; instr = i; op = o;
        @(posedge clk); #1;
        start  = 1'b0;
        bsy_ok = busy_r && !done_r;
        lat    = 0;
        dn_t   = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (done_r) begin
                lat    = c;
                dn_t   = done_t;
                bsy_ok = bsy_ok && !busy_r;
                break;
            end
            bsy_ok = bsy_ok && busy_r;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done_r) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int   lat, cyc, ndone, first, last, extra;
        logic bok, dnt, busy4;

        reset = 1'b1; start = 1'b0; instr = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 32'(result_r), 32'h0);
        chk("reset_flags", {27'b0, ovf_r, inv_r, busy_r, done_r, busy_t}, 32'h0);
        chk("reset_result_t", 32'(result_t), 32'h0);
        reset = 1'b0;

        vecs[0]  = '{ITOF, 16'h0028, 16'h4220, 16'h4220, 1'b0, 1'b0};
        vecs[1]  = '{ITOF, 16'h0183, 16'h43C2, 16'h43C1, 1'b0, 1'b0};
        vecs[2]  = '{ITOF, 16'h01FF, 16'h4400, 16'h43FF, 1'b0, 1'b0};
        vecs[3]  = '{ITOF, 16'h8000, 16'hC700, 16'hC700, 1'b0, 1'b0};
        vecs[4]  = '{ITOF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{ITOF, 16'hFFFF, 16'hBF80, 16'hBF80, 1'b0, 1'b0};
        vecs[6]  = '{ITOF, 16'h7FFF, 16'h4700, 16'h46FF, 1'b0, 1'b0};
        vecs[7]  = '{FTOI, 16'hC220, 16'hFFD8, 16'hFFD8, 1'b0, 1'b0};
        vecs[8]  = '{FTOI, 16'h3F00, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{FTOI, 16'hC700, 16'h8000, 16'h8000, 1'b0, 1'b0};
        vecs[10] = '{FTOI, 16'h4700, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
        vecs[11] = '{FTOI, 16'hFF80, 16'h8000, 16'h8000, 1'b1, 1'b0};
        vecs[12] = '{FTOI, 16'h3F80, 16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[13] = '{FTOI, 16'h4220, 16'h0028, 16'h0028, 1'b0, 1'b0};
        vecs[14] = '{FTOI, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[15] = '{FTOI, 16'h7F80, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
        vecs[16] = '{FTOI, 16'h46FF, 16'h7F80, 16'h7F80, 1'b0, 1'b0};
        vecs[17] = '{FTOI, 16'hC701, 16'h8000, 16'h8000, 1'b1, 1'b0};
        vecs[18] = '{FTOI, 16'h3FC0, 16'h0001, 16'h0001, 1'b0, 1'b0};
        vecs[19] = '{FTOI, 16'hBFC0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
        vecs[20] = '{5'h14, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vecs[21] = '{ITOF, 16'h0028, 16'h4220, 16'h4220, 1'b0, 1'b0};

        foreach (vecs[i]) begin
            issue(vecs[i].ins, vecs[i].opv, lat, bok, dnt);
            chk($sformatf("latency[%0d]", i), 32'(lat), 32'd3);
            chk($sformatf("busy_window[%0d]", i), 32'(bok), 32'd1);
            chk($sformatf("result[%0d]", i), 32'(result_r), 32'(vecs[i].res));
            chk($sformatf("ovf_inv[%0d]", i), {30'b0, ovf_r, inv_r}, {30'b0, vecs[i].ov, vecs[i].iv});
            chk($sformatf("trunc[%0d]", i), {13'b0, dnt, ovf_t, inv_t, result_t},
                {13'b0, 1'b1, vecs[i].ov, vecs[i].iv, vecs[i].res_t});
        end

        // inputs changed after accept, plus a start pulse while busy
        @(negedge clk);
        start = 1'b1; instr = FTOI; op = 16'h3F80;
        @(posedge clk); #1;
        start = 1'b0; instr = ITOF; op = 16'h4700;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(cyc);
        chk("capture_done_seen", 32'(cyc != 0), 32'd1);
        chk("capture_result", 32'(result_r), 32'h0001);
        chk("capture_ovf", 32'(ovf_r), 32'd0);
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_r || busy_r) extra++;
        end
        chk("busy_start_ignored", 32'(extra), 32'd0);
        chk("result_hold", 32'(result_r), 32'h0001);

        // start held high: accepts land in each done cycle
        @(negedge clk);
        start = 1'b1; instr = ITOF; op = 16'h0183;
        @(posedge clk); #1;
        ndone = 0; first = 0; last = 0; busy4 = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            if (c == 4) busy4 = busy_r;
            if (done_r) begin
                ndone++;
                if (first == 0) first = c;
                last = c;
                chk($sformatf("b2b_result@%0d", c), 32'(result_r), 32'h43C2);
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(ndone), 32'd3);
        chk("b2b_first_done", 32'(first), 32'd3);
        chk("b2b_last_done", 32'(last), 32'd11);
        chk("b2b_accept_in_done_cycle", 32'(busy4), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // reset while the op sits in S2
        @(negedge clk);
        start = 1'b1; instr = ITOF; op = 16'h01FF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_busy", 32'(busy_r), 32'd0);
        chk("midreset_result", 32'(result_r), 32'h0);
        chk("midreset_done", 32'(done_r), 32'd0);
        reset = 1'b0;
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_r) extra++;
        end
        chk("midreset_no_done", 32'(extra), 32'd0);
        issue(ITOF, 16'h0028, lat, bok, dnt);
        chk("post_reset_latency", 32'(lat), 32'd3);
        chk("post_reset_result", 32'(result_r), 32'h4220);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
